// File: rtl/hls_stream_packet_reader.sv
// Pops one last-terminated packet from an HLS_stream read port and replays it on a valid/ready port.
// Optional checksum: define STREAM_READER_CHECKSUM_EN to accumulate pkt_sum; otherwise pkt_sum is tied to 0.
module hls_stream_packet_reader #(
    parameter int WIDTH   = 16,
    parameter int MAX_LEN = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           stream_read_ready,
    output logic                           stream_read_valid,
    input  logic [WIDTH-1:0]               stream_data_bus,
    input  logic                           stream_last_bus,
    output logic                           word_valid,
    input  logic                           word_ready,
    output logic [WIDTH-1:0]               word_data,
    output logic                           word_last,
    output logic                           busy,
    output logic                           pkt_done,
    output logic [$clog2(MAX_LEN+1)-1:0]   pkt_len,
    output logic [WIDTH-1:0]               pkt_sum,
    output logic                           pkt_err
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, ARM, FETCH, HOLD, DONE} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   word_data_q;
    logic               word_last_q;
    logic               word_valid_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [LEN_W-1:0]   len_q;

    // The pop is a same-cycle response to the stream's ready flag, so it cannot be registered.
    assign stream_read_valid = (state_q == ARM) && stream_read_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            word_data_q  <= '0;
            word_last_q  <= 1'b0;
            word_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            len_q        <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ARM;
                        busy_q  <= 1'b1;
                        len_q   <= '0;
                        err_q   <= 1'b0;
                    end
                end
                ARM: begin
                    if (stream_read_ready) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    word_data_q  <= stream_data_bus;
                    word_last_q  <= stream_last_bus;
                    word_valid_q <= 1'b1;
                    len_q        <= len_q + LEN_W'(1);
                    state_q      <= HOLD;
                end
                HOLD: begin
                    if (word_ready) begin
                        word_valid_q <= 1'b0;
                        if (word_last_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (len_q == MAX_CNT) begin
                            err_q   <= 1'b1;
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ARM;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef STREAM_READER_CHECKSUM_EN
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;

    assign sum_d = sum_q + stream_data_bus;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
        end else if (state_q == IDLE && start) begin
            sum_q <= '0;
        end else if (state_q == FETCH) begin
            sum_q <= sum_d;
        end
    end

    assign pkt_sum = sum_q;
`else
    assign pkt_sum = '0;
`endif

    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;
    assign word_last  = word_last_q;
    assign busy       = busy_q;
    assign pkt_done   = done_q;
    assign pkt_len    = len_q;
    assign pkt_err    = err_q;

endmodule

// File: tb/tb_hls_stream_packet_reader.sv
// Scoreboard bench for hls_stream_packet_reader: a queue-based stream model feeds the DUT and a
// packet-level reference predicts each word and each packet result from the stream contents.
module tb_hls_stream_packet_reader;

    localparam int WIDTH   = 16;
    localparam int MAX_LEN = 4;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
`ifdef STREAM_READER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } word_t;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [WIDTH-1:0] sum;
        logic             err;
    } res_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stream_read_ready;
    logic             stream_read_valid;
    logic [WIDTH-1:0] stream_data_bus;
    logic             stream_last_bus;
    logic             word_valid;
    logic             word_ready;
    logic [WIDTH-1:0] word_data;
    logic             word_last;
    logic             busy;
    logic             pkt_done;
    logic [LEN_W-1:0] pkt_len;
    logic [WIDTH-1:0] pkt_sum;
    logic             pkt_err;

    hls_stream_packet_reader #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .stream_read_ready (stream_read_ready),
        .stream_read_valid (stream_read_valid),
        .stream_data_bus   (stream_data_bus),
        .stream_last_bus   (stream_last_bus),
        .word_valid        (word_valid),
        .word_ready        (word_ready),
        .word_data         (word_data),
        .word_last         (word_last),
        .busy              (busy),
        .pkt_done          (pkt_done),
        .pkt_len           (pkt_len),
        .pkt_sum           (pkt_sum),
        .pkt_err           (pkt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    word_t stream_q[$];
    word_t model_q[$];
    word_t exp_words[$];
    res_t  exp_res[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pop_total = 0;
    int model_consumed = 0;
    int last_pop_cyc = -100;
    int done_cnt = 0;
    bit rand_ready = 1'b0;
    bit stall_en = 1'b0;
    logic [WIDTH-1:0] stall_val = '0;
    int stall_left = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stream model: pop decided at the edge, head word presented for the following cycle.
    initial begin : stream_model
        bit    pend;
        word_t w;
        stream_read_ready = 1'b0;
        stream_data_bus   = '0;
        stream_last_bus   = 1'b0;
        forever begin
            @(negedge clk);
            pend = stream_read_valid;
            if (pend) begin
                check("pop_only_when_ready", 64'(stream_read_ready), 64'(1));
                last_pop_cyc = cyc;
            end
            @(posedge clk);
            #1;
            if (pend && stream_q.size() != 0) begin
                w = stream_q.pop_front();
                stream_data_bus = w.data;
                stream_last_bus = w.last;
                pop_total++;
            end
            stream_read_ready = (stream_q.size() != 0);
        end
    end

    initial begin : ready_driver
        word_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_en && word_valid && word_data == stall_val && stall_left > 0) begin
                word_ready = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                word_ready = ($urandom_range(0, 3) != 0);
            end else begin
                word_ready = 1'b1;
            end
        end
    end

    initial begin : monitor
        bit    prev_wv;
        word_t e;
        res_t  r;
        prev_wv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (word_valid && !prev_wv)
                    check("pop_to_valid_latency", 64'(cyc - last_pop_cyc), 64'(2));
                if (word_valid) begin
                    check("no_pop_while_holding", 64'(stream_read_valid), 64'(0));
                    if (exp_words.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_word: got data %0d with no word expected", word_data);
                    end else begin
                        e = exp_words[0];
                        check("word_data", 64'(word_data), 64'(e.data));
                        check("word_last", 64'(word_last), 64'(e.last));
                        if (word_ready) void'(exp_words.pop_front());
                    end
                end
                if (pkt_done) begin
                    done_cnt++;
                    check("word_valid_low_in_done", 64'(word_valid), 64'(0));
                    if (exp_res.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_done: got pkt_done with no packet expected");
                    end else begin
                        r = exp_res.pop_front();
                        check("pkt_len", 64'(pkt_len), 64'(r.len));
                        check("pkt_sum", 64'(pkt_sum), 64'(r.sum));
                        check("pkt_err", 64'(pkt_err), 64'(r.err));
                    end
                end
            end
            prev_wv = word_valid;
        end
    end

    // Reference: a packet is the stream prefix up to the first last flag, cut short at MAX_LEN.
    task automatic predict();
        int               n;
        logic [WIDTH-1:0] s;
        bit               fin;
        word_t            w;
        res_t             r;
        n   = 0;
        s   = '0;
        fin = 1'b0;
        r   = '0;
        while (!fin) begin
            if (model_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL predictor_underrun: got empty stream expected a word");
                break;
            end
            w = model_q.pop_front();
            n++;
            model_consumed++;
            s = s + w.data;
            exp_words.push_back(w);
            if (w.last) fin = 1'b1;
            else if (n == MAX_LEN) begin
                fin   = 1'b1;
                r.err = 1'b1;
            end
        end
        r.len = LEN_W'(n);
        r.sum = CK ? s : '0;
        exp_res.push_back(r);
    endtask

    task automatic push_word(input logic [WIDTH-1:0] d, input logic l);
        word_t w;
        w.data = d;
        w.last = l;
        stream_q.push_back(w);
        model_q.push_back(w);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_packet(input string name);
        int target;
        int k;
        target = done_cnt + 1;
        predict();
        pulse_start();
        @(negedge clk);
        check({name, "_busy_after_start"}, 64'(busy), 64'(1));
        k = 0;
        while (done_cnt < target && k < 400) begin
            @(posedge clk);
            k++;
        end
        check({name, "_done_seen"}, 64'(done_cnt >= target), 64'(1));
        @(negedge clk);
        @(negedge clk);
        check({name, "_idle_after_done"}, 64'(busy), 64'(0));
        check({name, "_pop_count"}, 64'(pop_total), 64'(model_consumed));
        check({name, "_words_left"}, 64'(exp_words.size()), 64'(0));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_stream_read_valid"}, 64'(stream_read_valid), 64'(0));
        check({name, "_word_valid"}, 64'(word_valid), 64'(0));
        check({name, "_word_data"}, 64'(word_data), 64'(0));
        check({name, "_word_last"}, 64'(word_last), 64'(0));
        check({name, "_busy"}, 64'(busy), 64'(0));
        check({name, "_pkt_done"}, 64'(pkt_done), 64'(0));
        check({name, "_pkt_len"}, 64'(pkt_len), 64'(0));
        check({name, "_pkt_sum"}, 64'(pkt_sum), 64'(0));
        check({name, "_pkt_err"}, 64'(pkt_err), 64'(0));
    endtask

    initial begin : stimulus
        int k;
        int n;
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        // Basic packet
        push_word(16'd28, 1'b0);
        push_word(16'd10, 1'b0);
        push_word(16'd7, 1'b0);
        push_word(16'd3, 1'b1);
        run_packet("s1");
        check("s1_len_held", 64'(pkt_len), 64'(4));
        check("s1_sum_held", 64'(pkt_sum), CK ? 64'(48) : 64'(0));
        check("s1_err_held", 64'(pkt_err), 64'(0));

        // Start on an empty stream; the word arrives 10 cycles later
        begin
            word_t w;
            int    target;
            w.data = 16'd5;
            w.last = 1'b1;
            model_q.push_back(w);
            target = done_cnt + 1;
            predict();
            pulse_start();
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check("s2_no_pop_while_empty", 64'(stream_read_valid), 64'(0));
            end
            stream_q.push_back(w);
            k = 0;
            while (done_cnt < target && k < 100) begin
                @(posedge clk);
                k++;
            end
            check("s2_done_seen", 64'(done_cnt >= target), 64'(1));
            @(negedge clk);
            check("s2_len", 64'(pkt_len), 64'(1));
            check("s2_sum", 64'(pkt_sum), CK ? 64'(5) : 64'(0));
            check("s2_pop_count", 64'(pop_total), 64'(model_consumed));
        end

        // Downstream stall of 20 cycles on word 10
        stall_val  = 16'd10;
        stall_left = 20;
        stall_en   = 1'b1;
        push_word(16'd28, 1'b0);
        push_word(16'd10, 1'b0);
        push_word(16'd7, 1'b0);
        push_word(16'd3, 1'b1);
        run_packet("s3");
        check("s3_stall_consumed", 64'(stall_left), 64'(0));
        stall_en = 1'b0;

        // Overlong packet: terminated with an error at MAX_LEN
        for (int i = 0; i < 6; i++) push_word(WIDTH'($urandom), 1'b0);
        run_packet("s4");
        check("s4_err", 64'(pkt_err), 64'(1));
        check("s4_len", 64'(pkt_len), 64'(MAX_LEN));
        check("s4_left_in_stream", 64'(stream_q.size()), 64'(2));
        push_word(WIDTH'($urandom), 1'b1);
        run_packet("s4_tail");

        // Ignored start mid-packet, then reset after the second word
        push_word(16'd101, 1'b0);
        push_word(16'd202, 1'b0);
        push_word(16'd303, 1'b0);
        push_word(16'd404, 1'b1);
        for (int i = 0; i < 2; i++) begin
            exp_words.push_back(model_q.pop_front());
            model_consumed++;
        end
        pulse_start();
        k = 0;
        while (exp_words.size() > 1 && k < 100) begin
            @(posedge clk);
            k++;
        end
        pulse_start();
        k = 0;
        while (exp_words.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        check("s5_two_words_seen", 64'(exp_words.size()), 64'(0));
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("s5_in_reset");
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_all_zero("s5_after_reset");
        check("s5_pop_count", 64'(pop_total), 64'(model_consumed));
        check("s5_done_count", 64'(done_cnt), 64'(5));
        run_packet("s5_resume");

        // Randomized packets with random downstream backpressure
        rand_ready = 1'b1;
        for (int p = 0; p < 12; p++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) push_word(WIDTH'($urandom), (i == n - 1));
            while (model_q.size() != 0) run_packet("rnd");
        end
        rand_ready = 1'b0;

        repeat (3) @(posedge clk);
        check("end_results_left", 64'(exp_res.size()), 64'(0));
        check("end_stream_left", 64'(stream_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
